// File: rtl/test_git_sched_if.sv
// Bundle between the requester front-ends and the shared toggle-detect
// scheduler. Master side = requesters (testbench), slave side = scheduler.
//
// Handshake: req[i] is a level request that stays high as long as requester
// i wants service. grant is one-hot and registered. A requester that drops
// req while granted ends its burst early (abort). cnt_valid is a one-cycle
// strobe qualifying edge_cnt/cnt_id/cnt_abort; there is no back-pressure.
interface test_git_sched_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] data_in;
    logic [N_REQ-1:0] grant;
    logic             sel_data;
    logic             busy;
    logic [CNT_W-1:0] edge_cnt;
    logic [ID_W-1:0]  cnt_id;
    logic             cnt_abort;
    logic             cnt_valid;
    logic [1:0]       state_dbg;

    modport master (
        output req, data_in,
        input  grant, sel_data, busy, edge_cnt, cnt_id, cnt_abort, cnt_valid,
        input  state_dbg
    );

    modport slave (
        input  req, data_in,
        output grant, sel_data, busy, edge_cnt, cnt_id, cnt_abort, cnt_valid,
        output state_dbg
    );
endinterface

// File: rtl/test_git_sched.sv
// Time-shares one single-bit sample-and-edge-detect datapath between N_REQ
// serial requesters. Each grant lasts BURST sample cycles; the number of bit
// transitions seen in the burst is reported with a one-cycle strobe.
//
// Build option: define TEST_GIT_SCHED_FIXED_PRIO_EN to make arbitration
// fixed priority (lowest index wins) instead of round-robin.
module test_git_sched #(
    parameter int N_REQ = 4,
    parameter int BURST = 8,
    parameter int CNT_W = 8,
    parameter int ID_W  = 2
) (
    input  logic           clk,
    input  logic           rst,
    test_git_sched_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic             rst1;
    logic             rst2;
    logic [N_REQ-1:0] grant_q;
    logic [ID_W-1:0]  gnt_id;
    logic [ID_W-1:0]  last_id;
    logic [7:0]       burst_ctr;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_nxt;
    logic             prev_q;
    logic             busy_q;
    logic [CNT_W-1:0] edge_q;
    logic [ID_W-1:0]  id_q;
    logic             abort_q;
    logic             valid_q;
    logic             sel;
    logic             first_smp;
    logic [ID_W-1:0]  win_id;
    logic             win_ok;

    // Shared datapath input: the granted requester's bit (zero when idle).
    assign sel       = |(grant_q & bus.data_in);
    // Cycle 0 of a burst only primes prev_q; nothing is counted.
    assign first_smp = (burst_ctr == 8'(BURST - 1));

    // Reset synchronizer: asserts immediately, releases after two edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst1 <= 1'b0;
            rst2 <= 1'b0;
        end else begin
            rst1 <= 1'b1;
            rst2 <= rst1;
        end
    end

    // Arbitration: pick the winner among the currently requesting inputs.
    always_comb begin
        win_id = '0;
        win_ok = 1'b0;
`ifdef TEST_GIT_SCHED_FIXED_PRIO_EN
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                win_id = ID_W'(i);
                win_ok = 1'b1;
            end
        end
`else
        // Walk offsets high to low so the smallest offset after last_id wins.
        for (int i = N_REQ; i >= 1; i--) begin
            int idx;
            idx = (int'(last_id) + i) % N_REQ;
            if (bus.req[idx]) begin
                win_id = ID_W'(idx);
                win_ok = 1'b1;
            end
        end
`endif
    end

    // Edge accumulator next value: count a transition, saturate at all-ones.
    always_comb begin
        acc_nxt = acc;
        if (!first_smp && (sel != prev_q) && (acc != '1)) begin
            acc_nxt = acc + CNT_W'(1);
        end
    end

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk or negedge rst2) begin
        if (!rst2) begin
            state     <= IDLE;
            grant_q   <= '0;
            gnt_id    <= '0;
            last_id   <= ID_W'(N_REQ - 1);
            burst_ctr <= '0;
            acc       <= '0;
            prev_q    <= 1'b0;
            busy_q    <= 1'b0;
            edge_q    <= '0;
            id_q      <= '0;
            abort_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state  <= ARB;
                        busy_q <= 1'b1;
                    end
                end
                ARB: begin
                    if (win_ok) begin
                        grant_q   <= N_REQ'(1) << win_id;
                        gnt_id    <= win_id;
                        last_id   <= win_id;
                        burst_ctr <= 8'(BURST - 1);
                        acc       <= '0;
                        state     <= RUN;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (!bus.req[gnt_id]) begin
                        // Requester left: this cycle's bit is discarded.
                        grant_q <= '0;
                        valid_q <= 1'b1;
                        edge_q  <= acc;
                        id_q    <= gnt_id;
                        abort_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        prev_q <= sel;
                        acc    <= acc_nxt;
                        if (burst_ctr == 8'd0) begin
                            grant_q <= '0;
                            valid_q <= 1'b1;
                            edge_q  <= acc_nxt;
                            id_q    <= gnt_id;
                            abort_q <= 1'b0;
                            state   <= DONE;
                        end else begin
                            burst_ctr <= burst_ctr - 8'd1;
                        end
                    end
                end
                DONE: begin
                    if (|bus.req) begin
                        state <= ARB;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.sel_data  = sel;
    assign bus.busy      = busy_q;
    assign bus.edge_cnt  = edge_q;
    assign bus.cnt_id    = id_q;
    assign bus.cnt_abort = abort_q;
    assign bus.cnt_valid = valid_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_test_git_sched.sv
// Testbench for test_git_sched: directed phases plus randomized bursts,
// checked against a transaction-level model (arbitration pick + transition
// count of the driven bit sequence). A second instance with CNT_W=2 covers
// counter saturation.
module tb_test_git_sched;

    localparam int N_REQ = 4;
    localparam int BURST = 8;
    localparam int CNT_W = 8;
    localparam int ID_W  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    test_git_sched_if #(.N_REQ(N_REQ), .CNT_W(CNT_W), .ID_W(ID_W)) bus ();
    test_git_sched_if #(.N_REQ(N_REQ), .CNT_W(2),     .ID_W(ID_W)) bus_s ();

    test_git_sched #(.N_REQ(N_REQ), .BURST(BURST), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    test_git_sched #(.N_REQ(N_REQ), .BURST(BURST), .CNT_W(2), .ID_W(ID_W)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_err    = 0;
    int model_last = N_REQ - 1;
    logic [CNT_W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: which requester should win given the request vector.
    function automatic int pick(logic [N_REQ-1:0] r, int last);
`ifdef TEST_GIT_SCHED_FIXED_PRIO_EN
        for (int i = 0; i < N_REQ; i++) if (r[i]) return i;
`else
        for (int off = 1; off <= N_REQ; off++) begin
            int idx;
            idx = (last + off) % N_REQ;
            if (r[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    // Reference: transitions within the first n sampled bits, clamped.
    function automatic int count_edges(logic [BURST-1:0] b, int n, int maxv);
        int c;
        c = 0;
        for (int k = 1; k < n; k++) if (b[k] != b[k-1]) c++;
        return (c > maxv) ? maxv : c;
    endfunction

    // ---------------- driver ----------------
    // Entered in the ARB cycle; leaves in the DONE cycle. abort_at < BURST
    // drops the granted request on that RUN cycle.
    task automatic run_burst(input int id, input logic [BURST-1:0] bits, input int abort_at);
        int n;
        n = (abort_at >= 0 && abort_at < BURST) ? abort_at : BURST;
        chk("arb_grant", 32'(bus.grant), 32'(0));
        chk("arb_busy", 32'(bus.busy), 32'(1));
        tick();
        chk("grant_onehot", 32'(bus.grant), 32'(1) << id);
        model_last = id;
        exp_q.push_back(CNT_W'(count_edges(bits, n, (1 << CNT_W) - 1)));
        for (int k = 0; k < n; k++) begin
            bus.data_in = N_REQ'($urandom());
            bus.data_in[id] = bits[k];
            #1;
            chk("sel_data", 32'(bus.sel_data), 32'(bits[k]));
            chk("run_grant", 32'(bus.grant), 32'(1) << id);
            tick();
        end
        if (n < BURST) begin
            bus.req[id] = 1'b0;
            tick();
        end
        chk("done_valid", 32'(bus.cnt_valid), 32'(1));
        chk("done_grant", 32'(bus.grant), 32'(0));
        chk("done_busy", 32'(bus.busy), 32'(1));
        chk("done_edge_cnt", 32'(bus.edge_cnt), 32'(exp_q.pop_front()));
        chk("done_cnt_id", 32'(bus.cnt_id), 32'(id));
        chk("done_abort", 32'(bus.cnt_abort), 32'(n < BURST));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int id;
        int ab;
        logic [BURST-1:0] pat;

        bus.req = '0;
        bus.data_in = '0;
        bus_s.req = '0;
        bus_s.data_in = '0;
        rst = 1'b0;

        // Reset: everything cleared.
        repeat (3) tick();
        chk("rst_outputs", 32'({bus.grant, bus.sel_data, bus.busy, bus.edge_cnt,
                                bus.cnt_id, bus.cnt_abort, bus.cnt_valid}), 32'(0));
        chk("rst_sat_grant", 32'(bus_s.grant), 32'(0));

        // Release with a request already pending; two clocks of synchronizer delay.
        bus.req = 4'b0001;
        rst = 1'b1;
        tick();
        chk("rel_busy1", 32'(bus.busy), 32'(0));
        tick();
        chk("rel_busy2", 32'(bus.busy), 32'(0));
        tick();
        // Directed alternating burst on requester 0.
        id = pick(bus.req, model_last);
        run_burst(id, 8'b01010101, -1);
        chk("dir_edge7", 32'(bus.edge_cnt), 32'(7));
        bus.req = '0;
        tick();
        chk("idle_busy", 32'(bus.busy), 32'(0));
        chk("idle_valid", 32'(bus.cnt_valid), 32'(0));
        chk("edge_held", 32'(bus.edge_cnt), 32'(7));

        // All requesting: successive bursts follow the arbitration rule.
        bus.req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                tick();
                chk("rr_gap_valid", 32'(bus.cnt_valid), 32'(0));
            end
            id = pick(bus.req, model_last);
            run_burst(id, BURST'($urandom()), -1);
        end

        // Random request sets, random data, occasional aborts.
        for (int i = 0; i < 12; i++) begin
            bus.req = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            tick();
            id = pick(bus.req, model_last);
            ab = $urandom_range(0, 2 * BURST - 1);
            run_burst(id, BURST'($urandom()), (ab < BURST) ? ab : -1);
        end

        // Directed abort: requester 2, data 0,1,1 then drop on RUN cycle 3.
        bus.req = 4'b0100;
        tick();
        id = pick(bus.req, model_last);
        run_burst(id, 8'b00000110, 3);
        chk("abort_edge1", 32'(bus.edge_cnt), 32'(1));
        chk("abort_flag", 32'(bus.cnt_abort), 32'(1));
        tick();
        chk("abort_idle_busy", 32'(bus.busy), 32'(0));

        // Drop on the final RUN cycle still counts as an abort.
        bus.req = 4'b1000;
        tick();
        id = pick(bus.req, model_last);
        run_burst(id, BURST'($urandom()), BURST - 1);
        tick();

        // Reset in the middle of a burst.
        bus.req = 4'b0011;
        tick();
        tick();
        repeat (4) tick();
        rst = 1'b0;
        #1;
        chk("midrst_grant", 32'(bus.grant), 32'(0));
        chk("midrst_busy", 32'(bus.busy), 32'(0));
        chk("midrst_valid", 32'(bus.cnt_valid), 32'(0));
        tick();
        chk("midrst_valid2", 32'(bus.cnt_valid), 32'(0));
        rst = 1'b1;
        model_last = N_REQ - 1;
        tick();
        tick();
        chk("midrst_rel_busy", 32'(bus.busy), 32'(0));
        tick();
        id = pick(bus.req, model_last);
        run_burst(id, BURST'($urandom()), -1);
        bus.req = '0;
        tick();

        // Saturation on the 2-bit counter instance.
        for (int r = 0; r < 2; r++) begin
            pat = (r == 0) ? 8'b01010101 : 8'b00000011;
            bus_s.req = 4'b0001;
            tick();
            tick();
            chk("sat_grant", 32'(bus_s.grant), 32'(1));
            for (int k = 0; k < BURST; k++) begin
                bus_s.data_in[0] = pat[k];
                tick();
            end
            chk("sat_valid", 32'(bus_s.cnt_valid), 32'(1));
            chk("sat_edge_cnt", 32'(bus_s.edge_cnt), 32'(count_edges(pat, BURST, 3)));
            bus_s.req = '0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    // Watchdog against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
